// File: rtl/hazard_md_if.sv
// Bundle of D/E/M/W hazard inputs and stall/forward outputs between the
// pipeline datapath (master) and the hazard controller (slave).
interface hazard_md_if;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [1:0] TuseRsD;
    logic [1:0] TuseRtD;
    logic       isMdD;
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic       RegWriteE;
    logic [4:0] WriteRegE;
    logic [1:0] TnewE;
    logic       RegWriteM;
    logic [4:0] WriteRegM;
    logic [1:0] TnewM;
    logic       RegWriteW;
    logic [4:0] WriteRegW;
    logic       mdStartE;
    logic       mdIsDivE;
    logic       stallF;
    logic       stallD;
    logic       flushE;
    logic [1:0] fwdRsD;
    logic [1:0] fwdRtD;
    logic [1:0] fwdRsE;
    logic [1:0] fwdRtE;
    logic       mdBusy;

    modport master (
        output rsD, rtD, TuseRsD, TuseRtD, isMdD, rsE, rtE,
               RegWriteE, WriteRegE, TnewE, RegWriteM, WriteRegM, TnewM,
               RegWriteW, WriteRegW, mdStartE, mdIsDivE,
        input  stallF, stallD, flushE, fwdRsD, fwdRtD, fwdRsE, fwdRtE, mdBusy
    );

    modport slave (
        input  rsD, rtD, TuseRsD, TuseRtD, isMdD, rsE, rtE,
               RegWriteE, WriteRegE, TnewE, RegWriteM, WriteRegM, TnewM,
               RegWriteW, WriteRegW, mdStartE, mdIsDivE,
        output stallF, stallD, flushE, fwdRsD, fwdRtD, fwdRsE, fwdRtE, mdBusy
    );
endinterface

// File: rtl/hazard_md_ctrl.sv
// Tuse/Tnew hazard controller with forwarding selects and mult/div busy sequencer.
// Optional HAZARD_STATS_EN adds a saturating 32-bit stall-cycle counter (stallCnt).
module hazard_md_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    hazard_md_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stallCnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    function automatic logic match(input logic [4:0] x, input logic rw, input logic [4:0] wr);
        return rw && (wr == x) && (x != 5'd0);
    endfunction

    // Index 0 = rs, 1 = rt, for both the D-stage and E-stage operand paths.
    logic [4:0] src_d   [2];
    logic [1:0] tuse_d  [2];
    logic [4:0] src_e   [2];
    logic       stall_src [2];
    logic [1:0] fwd_d   [2];
    logic [1:0] fwd_e   [2];

    assign src_d[0]  = hz.rsD;
    assign src_d[1]  = hz.rtD;
    assign tuse_d[0] = hz.TuseRsD;
    assign tuse_d[1] = hz.TuseRtD;
    assign src_e[0]  = hz.rsE;
    assign src_e[1]  = hz.rtE;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic m_d, e_d, w_d, m_e, w_e;
            assign e_d = match(src_d[gi], hz.RegWriteE, hz.WriteRegE);
            assign m_d = match(src_d[gi], hz.RegWriteM, hz.WriteRegM);
            assign w_d = match(src_d[gi], hz.RegWriteW, hz.WriteRegW);
            assign m_e = match(src_e[gi], hz.RegWriteM, hz.WriteRegM);
            assign w_e = match(src_e[gi], hz.RegWriteW, hz.WriteRegW);

            assign stall_src[gi] = (e_d && (hz.TnewE > tuse_d[gi])) ||
                                   (m_d && (hz.TnewM > tuse_d[gi]));

            // A not-yet-ready M producer shadows any older W copy; the stall covers it.
            assign fwd_d[gi] = m_d ? ((hz.TnewM == 2'd0) ? 2'b01 : 2'b00) :
                               w_d ? 2'b10 : 2'b00;
            assign fwd_e[gi] = (m_e && (hz.TnewM == 2'd0)) ? 2'b01 :
                               w_e ? 2'b10 : 2'b00;
        end
    endgenerate

    logic stall_md, stall;

    assign stall_md  = hz.isMdD && ((state_reg == BUSY) || hz.mdStartE);
    assign stall     = stall_src[0] | stall_src[1] | stall_md;

    assign hz.stallF = stall;
    assign hz.stallD = stall;
    assign hz.flushE = stall;
    assign hz.fwdRsD = fwd_d[0];
    assign hz.fwdRtD = fwd_d[1];
    assign hz.fwdRsE = fwd_e[0];
    assign hz.fwdRtE = fwd_e[1];
    assign hz.mdBusy = (state_reg == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A start arriving while busy is dropped: the D-stage stall prevents it in legal code.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (hz.mdStartE) begin
                    state_next = BUSY;
                    cnt_next   = hz.mdIsDivE ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Self-checking bench for hazard_md_ctrl: combinational vector table plus
// mult/div and reset sequences checked through an expected-value queue.
module tb_hazard_md_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_md_if hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    hazard_md_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .hz       (hz)
`ifdef HAZARD_STATS_EN
        ,
        .stallCnt (stall_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [4:0] rsD, rtD;
        logic [1:0] tuseRs, tuseRt;
        logic       isMd;
        logic [4:0] rsE, rtE;
        logic       rwE;
        logic [4:0] wrE;
        logic [1:0] tnE;
        logic       rwM;
        logic [4:0] wrM;
        logic [1:0] tnM;
        logic       rwW;
        logic [4:0] wrW;
        logic       e_stall;
        logic [1:0] e_frsd, e_frtd, e_frse, e_frte;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q [$];
    vec_t vecs [$];

    function automatic vec_t mk(string nm,
            logic [4:0] rsD, logic [1:0] tuseRs, logic [4:0] rtD, logic [1:0] tuseRt, logic isMd,
            logic [4:0] rsE, logic [4:0] rtE,
            logic rwE, logic [4:0] wrE, logic [1:0] tnE,
            logic rwM, logic [4:0] wrM, logic [1:0] tnM,
            logic rwW, logic [4:0] wrW,
            logic st, logic [1:0] frsd, logic [1:0] frtd, logic [1:0] frse, logic [1:0] frte);
        vec_t v;
        v.name = nm; v.rsD = rsD; v.tuseRs = tuseRs; v.rtD = rtD; v.tuseRt = tuseRt; v.isMd = isMd;
        v.rsE = rsE; v.rtE = rtE; v.rwE = rwE; v.wrE = wrE; v.tnE = tnE;
        v.rwM = rwM; v.wrM = wrM; v.tnM = tnM; v.rwW = rwW; v.wrW = wrW;
        v.e_stall = st; v.e_frsd = frsd; v.e_frtd = frtd; v.e_frse = frse; v.e_frte = frte;
        return v;
    endfunction

    function automatic logic [11:0] pack_exp(logic st, logic [1:0] a, logic [1:0] b,
                                             logic [1:0] c, logic [1:0] d, logic busy);
        return {st, st, st, a, b, c, d, busy};
    endfunction

    task automatic clear_inputs();
        hz.rsD = 0; hz.rtD = 0; hz.TuseRsD = 2'b11; hz.TuseRtD = 2'b11; hz.isMdD = 0;
        hz.rsE = 0; hz.rtE = 0;
        hz.RegWriteE = 0; hz.WriteRegE = 0; hz.TnewE = 0;
        hz.RegWriteM = 0; hz.WriteRegM = 0; hz.TnewM = 0;
        hz.RegWriteW = 0; hz.WriteRegW = 0;
        hz.mdStartE = 0; hz.mdIsDivE = 0;
    endtask

    task automatic check_out(input string nm);
        logic [11:0] act, e;
        @(negedge clk);
        act = {hz.stallF, hz.stallD, hz.flushE, hz.fwdRsD, hz.fwdRtD, hz.fwdRsE, hz.fwdRtE, hz.mdBusy};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty, got=%03h", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL %s got=%03h want=%03h", nm, act, e);
            end else begin
                $display("ok   %s out=%03h", nm, act);
            end
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk); #1;
        clear_inputs();
        hz.rsD = v.rsD; hz.rtD = v.rtD; hz.TuseRsD = v.tuseRs; hz.TuseRtD = v.tuseRt;
        hz.isMdD = v.isMd; hz.rsE = v.rsE; hz.rtE = v.rtE;
        hz.RegWriteE = v.rwE; hz.WriteRegE = v.wrE; hz.TnewE = v.tnE;
        hz.RegWriteM = v.rwM; hz.WriteRegM = v.wrM; hz.TnewM = v.tnM;
        hz.RegWriteW = v.rwW; hz.WriteRegW = v.wrW;
        exp_q.push_back(pack_exp(v.e_stall, v.e_frsd, v.e_frtd, v.e_frse, v.e_frte, 1'b0));
        check_out(v.name);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Start cycle stalls, lat busy cycles stall, then the unit is free again.
    task automatic run_md(input logic is_div, input int lat, input string nm);
        @(posedge clk); #1;
        clear_inputs();
        hz.isMdD = 1'b1; hz.mdStartE = 1'b1; hz.mdIsDivE = is_div;
        exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 0));
        for (int k = 0; k < lat; k++) exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 1));
        exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0));
        check_out({nm, "_start"});
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            hz.mdStartE = 1'b0;
            check_out($sformatf("%s_cyc%0d", nm, k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //            name          rsD tRs rtD tRt md rsE rtE rwE wrE tE rwM wrM tM rwW wrW  st frsd frtd frse frte
        vecs.push_back(mk("idle",      0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_E_beq",  1, 0, 0, 3, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("lw_M_tn1",  1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1,   1, 0, 0, 0, 0));
        vecs.push_back(mk("lw_M_tn0",  1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 0, 0, 0));
        vecs.push_back(mk("m_over_w",  3, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 3,   0, 1, 0, 0, 0));
        vecs.push_back(mk("reg0_E",    0, 0, 0, 3, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk("reg0_MW",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk("w_rt",      0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   0, 0, 2, 0, 0));
        vecs.push_back(mk("tn1_tu1",   0, 3, 7, 1, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk("tn2_tu1",   0, 3, 7, 1, 0, 0, 0, 1, 7, 2, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("tuse3",     7, 3, 0, 3, 0, 0, 0, 1, 7, 2, 1, 7, 2, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk("fwd_E",     0, 3, 0, 3, 0, 4, 6, 0, 0, 0, 1, 4, 0, 1, 6,   0, 0, 0, 1, 2));
        vecs.push_back(mk("fwd_E_mw",  0, 3, 0, 3, 0, 9, 9, 0, 0, 0, 1, 9, 0, 1, 9,   0, 0, 0, 1, 1));
        vecs.push_back(mk("no_rwM",    1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk("md_idle",   0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));

        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0));
        check_out("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        do_reset();
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset got=%0d want=0", stall_cnt);
        end else $display("ok   stats_reset cnt=%0d", stall_cnt);
`endif
        run_md(1'b0, 5, "mult");
`ifdef HAZARD_STATS_EN
        total++;
        if (stall_cnt !== 32'd6) begin
            bad++;
            $display("FAIL stats_mult got=%0d want=6", stall_cnt);
        end else $display("ok   stats_mult cnt=%0d", stall_cnt);
`endif
        run_md(1'b1, 10, "div");

        // Reset three cycles into a div aborts the busy period.
        @(posedge clk); #1;
        clear_inputs();
        hz.isMdD = 1'b1; hz.mdStartE = 1'b1; hz.mdIsDivE = 1'b1;
        exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 0));
        check_out("rst_div_start");
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            hz.mdStartE = 1'b0;
            exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 1));
            check_out($sformatf("rst_div_cyc%0d", k));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0));
        check_out("rst_div_after");

        // A fresh mult after the abort must run its full latency.
        run_md(1'b0, 5, "mult2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
